// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Checks the output of an odd-ratio clock divider from the source clock
// domain. The divided clock is synchronised, its rising edges are found, and
// every period is measured in source-clock cycles (period and high time).
// Each measurement is compared to the expected values. The block reports a
// lock after enough good measurements in a row, and flags period, duty and
// missing-edge (timeout) errors.

module div_clk_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int EXP_HIGH   = 2,
  parameter int HIGH_TOL   = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_PERIOD  = 2'b01;
  localparam logic [1:0] CODE_DUTY    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]  EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  EXP_HIGH_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  HIGH_TOL_C   = CNT_W'(HIGH_TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C       = GOOD_W'(LOCK_CNT);

  // Synchroniser (s1, s2) and edge history (s3)
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Control state and measurement counters
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;

  // Registered outputs
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  // Helper terms shared by the state logic
  logic              edge_det;
  logic              timeout_hit;
  logic              period_bad;
  logic              duty_bad;
  logic [CNT_W-1:0]  hi_diff;
  logic [CNT_W-1:0]  per_inc;
  logic [CNT_W-1:0]  hi_inc;
  logic [GOOD_W-1:0] good_inc;

  // Shift the raw divided clock through the synchroniser and history flop
  always_comb begin
    s1_d = div_clk_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Edge detection, saturating increments and the measurement checks
  always_comb begin
    edge_det    = s2_q & ~s3_q;
    timeout_hit = (per_cnt_q >= TIMEOUT_C);

    per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;

    if (s2_q && (hi_cnt_q != CNT_MAX)) begin
      hi_inc = hi_cnt_q + 1'b1;
    end else begin
      hi_inc = hi_cnt_q;
    end

    good_inc = (good_q == LOCK_C) ? good_q : good_q + 1'b1;

    // Subtract the smaller from the larger so the difference never wraps
    if (hi_cnt_q > EXP_HIGH_C) begin
      hi_diff = hi_cnt_q - EXP_HIGH_C;
    end else begin
      hi_diff = EXP_HIGH_C - hi_cnt_q;
    end

    period_bad = (per_cnt_q != EXP_PERIOD_C);
    duty_bad   = (hi_diff > HIGH_TOL_C);
  end

  // Next-state logic: state machine, counters, lock tracking and outputs
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    good_d       = good_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    if (!en) begin
      // Disabled: drop any measurement in progress and clear everything
      state_d    = ST_IDLE;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      good_d     = '0;
      period_d   = '0;
      high_d     = '0;
      locked_d   = 1'b0;
      err_code_d = CODE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          per_cnt_d  = '0;
          hi_cnt_d   = '0;
          good_d     = '0;
          period_d   = '0;
          high_d     = '0;
          locked_d   = 1'b0;
          err_code_d = CODE_NONE;
        end

        ST_WAIT: begin
          if (timeout_hit) begin
            // Still no edge: report it and start a fresh wait window
            err_d      = 1'b1;
            err_code_d = CODE_TIMEOUT;
            good_d     = '0;
            locked_d   = 1'b0;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
          end else if (edge_det) begin
            // First edge only opens a period; there is nothing to publish yet
            state_d   = ST_MEASURE;
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
          end else begin
            per_cnt_d = per_inc;
          end
        end

        ST_MEASURE: begin
          if (timeout_hit) begin
            // Timeout outranks any edge that arrives in the same cycle
            state_d    = ST_WAIT;
            err_d      = 1'b1;
            err_code_d = CODE_TIMEOUT;
            good_d     = '0;
            locked_d   = 1'b0;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
          end else if (edge_det) begin
            period_d     = per_cnt_q;
            high_d       = hi_cnt_q;
            meas_valid_d = 1'b1;
            per_cnt_d    = CNT_W'(1);
            hi_cnt_d     = CNT_W'(1);
            if (period_bad) begin
              err_d      = 1'b1;
              err_code_d = CODE_PERIOD;
              good_d     = '0;
              locked_d   = 1'b0;
            end else if (duty_bad) begin
              err_d      = 1'b1;
              err_code_d = CODE_DUTY;
              good_d     = '0;
              locked_d   = 1'b0;
            end else begin
              good_d     = good_inc;
              locked_d   = (good_inc == LOCK_C);
              err_code_d = CODE_NONE;
            end
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Synchroniser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      good_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      good_q       <= good_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Testbench for div_clk_monitor: a constant vector table covers reset and the
// first measurement, then directed patterns and random traffic are compared
// every cycle against a timestamp-based reference model.

module tb_div_clk_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 5;
  localparam int EXP_HIGH   = 2;
  localparam int HIGH_TOL   = 1;
  localparam int LOCK_CNT   = 4;
  localparam int TIMEOUT    = 64;
  localparam int MAXC       = 16384;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_clk_in = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;

  div_clk_monitor #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
    .HIGH_TOL(HIGH_TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .div_clk_in(div_clk_in), .en(en),
    .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .locked(locked), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;

  // Reference model: the input is remembered per clock index, edges and
  // counts are derived from timestamps rather than running counters.
  bit seen [0:MAXC-1];
  int n = 0;
  int m_mode = 0;      // 0 idle, 1 waiting for first edge, 2 measuring
  int m_base = 0;      // period count at clock index k is k - m_base
  int m_edge_t = 0;    // clock index at which the current period started
  int m_good = 0;
  int m_period = 0;
  int m_high = 0;
  int m_code = 0;
  bit m_mv = 1'b0;
  bit m_err = 1'b0;
  bit m_locked = 1'b0;

  // Per-sequence tallies taken from the DUT outputs
  int mv_cnt, err_cnt, lock_rises, lock_mv, first_err_code;
  int first_err_prev_locked, first_err_locked, first_mv_cycle, run_cycle;
  int lock_with_mv;
  bit prev_locked = 1'b0;

  typedef struct {
    logic r;
    logic e;
    logic d;
    int   period;
    int   high;
    logic mv;
    logic lk;
    logic er;
    int   code;
  } vec_t;

  vec_t vecs [0:12];

  function automatic bit seen_at(int i);
    return (i >= 0) ? seen[i] : 1'b0;
  endfunction

  function automatic int sat(int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic d);
    int per;
    int hi;
    int diff;
    bit edge_now;
    edge_now = seen_at(n - 2) && !seen_at(n - 3);
    per      = n - m_base;
    m_mv     = 1'b0;
    m_err    = 1'b0;
    if (r || !e) begin
      m_mode = 0; m_period = 0; m_high = 0; m_locked = 1'b0; m_code = 0; m_good = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_base = n + 1;
    end else if (per >= TIMEOUT) begin
      m_err = 1'b1; m_code = 3; m_locked = 1'b0; m_good = 0; m_mode = 1; m_base = n + 1;
    end else if (edge_now) begin
      if (m_mode == 2) begin
        hi = 0;
        for (int i = m_edge_t - 2; i <= n - 3; i++) hi += int'(seen_at(i));
        diff     = (hi > EXP_HIGH) ? hi - EXP_HIGH : EXP_HIGH - hi;
        m_period = sat(per);
        m_high   = sat(hi);
        m_mv     = 1'b1;
        if (per != EXP_PERIOD) begin
          m_err = 1'b1; m_code = 1; m_good = 0; m_locked = 1'b0;
        end else if (diff > HIGH_TOL) begin
          m_err = 1'b1; m_code = 2; m_good = 0; m_locked = 1'b0;
        end else begin
          m_good   = (m_good + 1 > LOCK_CNT) ? LOCK_CNT : m_good + 1;
          m_locked = (m_good == LOCK_CNT);
          m_code   = 0;
        end
      end
      m_mode = 2; m_edge_t = n; m_base = n;
    end
    if (r) begin
      seen[n] = 1'b0;
      if (n >= 1) seen[n-1] = 1'b0;
      if (n >= 2) seen[n-2] = 1'b0;
    end else begin
      seen[n] = d;
    end
    n++;
  endtask

  task automatic clear_tally();
    mv_cnt = 0; err_cnt = 0; lock_rises = 0; lock_mv = -1; lock_with_mv = 0;
    first_err_code = -1; first_err_prev_locked = -1; first_err_locked = -1;
    first_mv_cycle = -1; run_cycle = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample the DUT
  task automatic applyStimulus(input logic r, input logic e, input logic d);
    if (n >= MAXC) begin
      $display("[TB] FAIL cycle_budget: index %0d reached limit %0d", n, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    @(negedge clk);
    rst = r; en = e; div_clk_in = d;
    @(posedge clk);
    model_step(r, e, d);
    #1;
    if (meas_valid) begin
      mv_cnt++;
      if (first_mv_cycle < 0) first_mv_cycle = run_cycle;
    end
    if (err) begin
      err_cnt++;
      if (first_err_code < 0) begin
        first_err_code        = int'(err_code);
        first_err_prev_locked = int'(prev_locked);
        first_err_locked      = int'(locked);
      end
    end
    if (locked && !prev_locked) begin
      lock_rises++;
      if (lock_mv < 0) begin
        lock_mv      = mv_cnt;
        lock_with_mv = int'(meas_valid);
      end
    end
    prev_locked = locked;
    run_cycle++;
  endtask

  task automatic checkOutput(input string name);
    compared++;
    if (int'(period) != m_period || int'(high_cnt) != m_high || meas_valid != m_mv ||
        locked != m_locked || err != m_err || int'(err_code) != m_code) begin
      failed++;
      $display("[TB] FAIL %s cyc=%0d got p=%0d h=%0d mv=%0b lk=%0b err=%0b code=%0d want p=%0d h=%0d mv=%0b lk=%0b err=%0b code=%0d",
               name, n, period, high_cnt, meas_valid, locked, err, err_code,
               m_period, m_high, m_mv, m_locked, m_err, m_code);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int idx, input logic r, input logic e, input logic d,
                         input int p, input int h, input logic mv, input int code);
    vecs[idx].r = r; vecs[idx].e = e; vecs[idx].d = d;
    vecs[idx].period = p; vecs[idx].high = h; vecs[idx].mv = mv;
    vecs[idx].lk = 1'b0; vecs[idx].er = 1'b0; vecs[idx].code = code;
  endtask

  task automatic run_pattern(input string name, input logic [15:0] pat, input int len,
                             input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int ph = 0; ph < len; ph++) begin
        applyStimulus(1'b0, 1'b1, pat[len-1-ph]);
        checkOutput(name);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind, p, h, reps, len;
    logic d;

    // Reset with a toggling input, then the first two edges of 11100
    add_vec(0,  1, 1, 1, 0, 0, 0, 0);
    add_vec(1,  1, 1, 0, 0, 0, 0, 0);
    add_vec(2,  1, 1, 1, 0, 0, 0, 0);
    add_vec(3,  0, 1, 1, 0, 0, 0, 0);
    add_vec(4,  0, 1, 1, 0, 0, 0, 0);
    add_vec(5,  0, 1, 1, 0, 0, 0, 0);
    add_vec(6,  0, 1, 0, 0, 0, 0, 0);
    add_vec(7,  0, 1, 0, 0, 0, 0, 0);
    add_vec(8,  0, 1, 1, 0, 0, 0, 0);
    add_vec(9,  0, 1, 1, 0, 0, 0, 0);
    add_vec(10, 0, 1, 1, 5, 3, 1, 0);
    add_vec(11, 0, 1, 0, 5, 3, 0, 0);
    add_vec(12, 0, 1, 0, 5, 3, 0, 0);

    clear_tally();
    for (int i = 0; i <= 12; i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].d);
      compared++;
      if (int'(period) != vecs[i].period || int'(high_cnt) != vecs[i].high ||
          meas_valid != vecs[i].mv || locked != vecs[i].lk || err != vecs[i].er ||
          int'(err_code) != vecs[i].code) begin
        failed++;
        $display("[TB] FAIL vec%0d got p=%0d h=%0d mv=%0b lk=%0b err=%0b code=%0d want p=%0d h=%0d mv=%0b lk=%0b err=%0b code=%0d",
                 i, period, high_cnt, meas_valid, locked, err, err_code,
                 vecs[i].period, vecs[i].high, vecs[i].mv, vecs[i].lk, vecs[i].er, vecs[i].code);
      end
    end

    // Divide-by-5 with high time 3: lock on the 4th measurement
    run_pattern("div5", 16'b11100, 5, 8);
    checkValue("lock_at_4th_mv", lock_mv, 4);
    checkValue("lock_with_mv", lock_with_mv, 1);
    checkValue("div5_no_err", err_cnt, 0);

    // Divide-by-7 breaks lock with a period error
    clear_tally();
    run_pattern("div7", 16'b1110000, 7, 3);
    checkValue("div7_err_code", first_err_code, 1);
    checkValue("div7_locked_before", first_err_prev_locked, 1);
    checkValue("div7_locked_at_err", first_err_locked, 0);
    clear_tally();
    run_pattern("relock5", 16'b11100, 5, 8);
    checkValue("relock_lock_mv", lock_mv, 5);
    checkValue("relock_locked", int'(locked), 1);

    // Duty out of tolerance, then the minimum-deviation pattern
    clear_tally();
    run_pattern("duty4", 16'b11110, 5, 6);
    checkValue("duty4_err_cnt", err_cnt, 5);
    checkValue("duty4_code", int'(err_code), 2);
    checkValue("duty4_no_lock", lock_rises, 0);
    checkValue("duty4_unlocked", int'(locked), 0);
    clear_tally();
    run_pattern("duty2", 16'b11000, 5, 8);
    checkValue("duty2_high", int'(high_cnt), 2);
    checkValue("duty2_err_cnt", err_cnt, 1);
    checkValue("duty2_lock_mv", lock_mv, 5);

    // Stuck-low input: one timeout from MEASURE, a second from WAIT_EDGE
    clear_tally();
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("hold0");
    end
    checkValue("timeout_err_cnt", err_cnt, 2);
    checkValue("timeout_code", first_err_code, 3);
    checkValue("timeout_prev_locked", first_err_prev_locked, 1);
    checkValue("timeout_locked", first_err_locked, 0);
    checkValue("timeout_no_mv", mv_cnt, 0);
    clear_tally();
    run_pattern("resume", 16'b11100, 5, 8);
    checkValue("resume_first_mv", first_mv_cycle, 7);
    checkValue("resume_lock_mv", lock_mv, 4);

    // Drop enable mid-period, then re-enable at a period boundary
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("pre_drop");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("pre_drop");
    clear_tally();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("en_low");
    checkValue("en_drop_period", int'(period), 0);
    checkValue("en_drop_locked", int'(locked), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("en_low");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("en_low");
    checkValue("en_drop_no_pulse", mv_cnt + err_cnt, 0);
    clear_tally();
    run_pattern("reen", 16'b11100, 5, 8);
    checkValue("reen_lock_mv", lock_mv, 4);
    checkValue("reen_no_err", err_cnt, 0);

    // Random traffic against the reference model
    for (int b = 0; b < 150 && n < MAXC - 400; b++) begin
      kind = $urandom_range(0, 11);
      if (kind <= 7) begin
        if (kind <= 4) begin
          p = 5;
          h = $urandom_range(1, 4);
        end else begin
          p = $urandom_range(3, 9);
          h = $urandom_range(1, p - 1);
        end
        reps = $urandom_range(2, 6);
        for (int r = 0; r < reps; r++) begin
          for (int ph = 0; ph < p; ph++) begin
            applyStimulus(1'b0, 1'b1, (ph < h) ? 1'b1 : 1'b0);
            checkOutput("rand_pattern");
          end
        end
      end else if (kind == 8) begin
        for (int i = 0; i < 20; i++) begin
          d = 1'($urandom_range(0, 1));
          applyStimulus(1'b0, 1'b1, d);
          checkOutput("rand_bits");
        end
      end else if (kind == 9) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          d = 1'($urandom_range(0, 1));
          applyStimulus(1'b0, 1'b0, d);
          checkOutput("rand_en_low");
        end
      end else if (kind == 10) begin
        len = $urandom_range(60, 140);
        for (int i = 0; i < len; i++) begin
          applyStimulus(1'b0, 1'b1, 1'b0);
          checkOutput("rand_hold");
        end
      end else begin
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) begin
          d = 1'($urandom_range(0, 1));
          applyStimulus(1'b1, 1'($urandom_range(0, 1)), d);
          checkOutput("rand_rst");
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
